// File: rtl/isp_frame_ctrl_if.sv
// Source/pipeline-side bundle of the ISP frame sequencer.
// The controller takes the master view; the source and pipeline take the slave view.
interface isp_frame_ctrl_if #(
    parameter int width  = 320,
    parameter int height = 240,
    parameter int DATA_W = 8
);
    localparam int COL_W = $clog2(width);
    localparam int ROW_W = $clog2(height);

    logic              iStart;
    logic              iValid;
    logic [DATA_W-1:0] iData;
    logic              oReady;
    logic              oPipeReset;
    logic              oPipeValid;
    logic [DATA_W-1:0] oPipeData;
    logic              iPipeOutValid;
    logic              iPipeDone;
    logic [COL_W-1:0]  oCol;
    logic [ROW_W-1:0]  oRow;
    logic [1:0]        oBayer;
    logic              oBusy;
    logic              oFrameDone;
    logic              oError;

    modport master (
        input  iStart, iValid, iData, iPipeOutValid, iPipeDone,
        output oReady, oPipeReset, oPipeValid, oPipeData,
               oCol, oRow, oBayer, oBusy, oFrameDone, oError
    );

    modport slave (
        output iStart, iValid, iData, iPipeOutValid, iPipeDone,
        input  oReady, oPipeReset, oPipeValid, oPipeData,
               oCol, oRow, oBayer, oBusy, oFrameDone, oError
    );
endinterface

// File: rtl/isp_frame_ctrl.sv
// Frame sequencer: resets the ISP pipeline, feeds one raster frame of Bayer pixels,
// flushes until the pipeline reports done, then checks the output pixel count.
module isp_frame_ctrl #(
    parameter int width    = 320,
    parameter int height   = 240,
    parameter int flushMax = 4096,
    parameter int DATA_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    isp_frame_ctrl_if.master bus
);
    localparam int PIX    = width * height;
    localparam int COL_W  = $clog2(width);
    localparam int ROW_W  = $clog2(height);
    localparam int OCNT_W = $clog2(PIX + 2);
    localparam int FL_W   = $clog2(flushMax + 1);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(width - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(height - 1);
    localparam logic [OCNT_W-1:0] OCNT_PIX = OCNT_W'(PIX);
    localparam logic [OCNT_W-1:0] OCNT_SAT = OCNT_W'(PIX + 1);
    localparam logic [FL_W-1:0]   FL_LAST  = FL_W'(flushMax - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRST, S_FEED, S_FLUSH, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_prst;
    logic [COL_W-1:0]    r_ccnt;
    logic [ROW_W-1:0]    r_rcnt;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [DATA_W-1:0]   r_data;
    logic                r_pvalid;
    logic [OCNT_W-1:0]   r_ocnt;
    logic [FL_W-1:0]     r_flush;
    logic                r_error;

    logic w_start;
    logic w_accept;
    logic w_last;
    logic w_timeout;
    logic w_cnt_err;
    logic w_counting;

    assign w_start    = (r_state == S_IDLE) && bus.iStart;
    assign w_accept   = (r_state == S_FEED) && bus.iValid;
    assign w_last     = w_accept && (r_ccnt == COL_LAST) && (r_rcnt == ROW_LAST);
    assign w_timeout  = (r_state == S_FLUSH) && !bus.iPipeDone && (r_flush == FL_LAST);
    assign w_cnt_err  = (r_state == S_DONE) && (r_ocnt != OCNT_PIX);
    assign w_counting = (r_state == S_FEED) || (r_state == S_FLUSH);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.iStart) w_next = S_PRST;
            S_PRST:  if (r_prst) w_next = S_FEED;
            S_FEED:  if (w_last) w_next = S_FLUSH;
            S_FLUSH: if (bus.iPipeDone || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prst   <= 1'b0;
            r_ccnt   <= '0;
            r_rcnt   <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_data   <= '0;
            r_pvalid <= 1'b0;
            r_ocnt   <= '0;
            r_flush  <= '0;
            r_error  <= 1'b0;
        end else begin
            // PRST holds for exactly two cycles: r_prst marks the second one
            r_prst <= (r_state == S_PRST) && !r_prst;
            if (w_start) begin
                r_ccnt   <= '0;
                r_rcnt   <= '0;
                r_col    <= '0;
                r_row    <= '0;
                r_data   <= '0;
                r_pvalid <= 1'b0;
                r_ocnt   <= '0;
                r_flush  <= '0;
                r_error  <= 1'b0;
            end
            case (r_state)
                S_FEED: begin
                    r_pvalid <= w_accept;
                    if (w_accept) begin
                        r_data <= bus.iData;
                        r_col  <= r_ccnt;
                        r_row  <= r_rcnt;
                        if (r_ccnt == COL_LAST) begin
                            r_ccnt <= '0;
                            r_rcnt <= r_rcnt + 1'b1;
                        end else begin
                            r_ccnt <= r_ccnt + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    r_pvalid <= 1'b1;
                    r_data   <= '0;
                    r_flush  <= r_flush + 1'b1;
                    if (w_timeout) r_error <= 1'b1;
                end
                S_DONE: begin
                    r_pvalid <= 1'b0;
                    if (w_cnt_err) r_error <= 1'b1;
                end
                default: ;
            endcase
            if (w_counting && bus.iPipeOutValid && (r_ocnt != OCNT_SAT))
                r_ocnt <= r_ocnt + 1'b1;
        end
    end

    assign bus.oReady     = (r_state == S_FEED);
    assign bus.oPipeReset = reset || (r_state == S_PRST);
    assign bus.oPipeValid = r_pvalid && w_counting;
    assign bus.oPipeData  = r_data;
    assign bus.oCol       = r_col;
    assign bus.oRow       = r_row;
    assign bus.oBayer     = {r_row[0], r_col[0]};
    assign bus.oBusy      = (r_state != S_IDLE);
    assign bus.oFrameDone = (r_state == S_DONE);
    // count error must be visible in the same cycle as oFrameDone
    assign bus.oError     = r_error || w_cnt_err;
endmodule

// File: tb/tb_isp_frame_ctrl.sv
// Directed bench for isp_frame_ctrl on a 4x2 frame with a small pipeline model.
module tb_isp_frame_ctrl;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int FM = 16;

    logic clk = 1'b0;
    logic reset;

    isp_frame_ctrl_if #(.width(W), .height(H), .DATA_W(8)) bus ();

    isp_frame_ctrl #(.width(W), .height(H), .flushMax(FM), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    int cyc = 0;
    bit gap_mode;
    int mtarget;
    bit mdone_en;
    int inj_at = -1;
    int sent = 8;
    bit acc_prev;
    int ready_cyc;
    int dq[$];
    int bq[$];
    int cq[$];
    int rq[$];
    int vq[$];
    int zero_flush, nz_flush, done_cnt, err_at_done, done_cyc, prst_cnt;
    int mirror_err, hold_err, gapfree_err, ready_after, last_pix_cyc;
    logic [2:0] pv_d;
    int mcnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        bit acc;
        bit outv;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.oPipeReset && !reset) prst_cnt++;
        if (bus.oFrameDone) begin
            done_cnt++;
            err_at_done = int'(bus.oError);
            done_cyc = cyc;
        end
        if (acc_prev && sent == 8) ready_after = int'(bus.oReady);
        if (ready_cyc > 0 && dq.size() < 8 && bus.oPipeValid != acc_prev) mirror_err++;
        if (bus.oPipeValid) begin
            if (dq.size() < 8) begin
                dq.push_back(int'(bus.oPipeData));
                bq.push_back(int'(bus.oBayer));
                cq.push_back(int'(bus.oCol));
                rq.push_back(int'(bus.oRow));
                vq.push_back(cyc);
                if (dq.size() == 8) last_pix_cyc = cyc;
            end else if (bus.oPipeData == 8'd0) zero_flush++;
            else nz_flush++;
        end else if (dq.size() > 0 && dq.size() < 8) begin
            if (int'(bus.oCol) != cq[cq.size()-1] || int'(bus.oRow) != rq[rq.size()-1]) hold_err++;
        end else if (last_pix_cyc > 0 && done_cnt == 0) begin
            gapfree_err++;
        end
        if (bus.oReady) ready_cyc++;
        // pipeline model: output valid trails input valid by two cycles
        pv_d = {pv_d[1:0], bus.oPipeValid};
        outv = pv_d[2] && (mcnt < mtarget);
        if (outv) mcnt++;
        bus.iPipeOutValid = outv;
        bus.iPipeDone = mdone_en && outv && (mcnt == mtarget);
        bus.iStart = 1'b0;
        if (inj_at >= 0 && ready_cyc == inj_at && bus.oReady) begin
            bus.iStart = 1'b1;
            bus.iPipeDone = 1'b1;
        end
        if (sent < 8) begin
            bus.iValid = gap_mode ? cyc[0] : 1'b1;
            bus.iData = 8'(sent + 1);
            acc = bus.iValid && bus.oReady;
            if (acc) sent++;
        end else begin
            bus.iValid = 1'b0;
            acc = 1'b0;
        end
        acc_prev = acc;
    endtask

    task automatic frame_begin(input bit gap, input int target, input bit den, input int inj);
        dq.delete(); bq.delete(); cq.delete(); rq.delete(); vq.delete();
        zero_flush = 0; nz_flush = 0; done_cnt = 0; err_at_done = -1; done_cyc = 0;
        prst_cnt = 0; mirror_err = 0; hold_err = 0; gapfree_err = 0; ready_after = -1;
        last_pix_cyc = 0; ready_cyc = 0; sent = 0; acc_prev = 1'b0; pv_d = '0; mcnt = 0;
        gap_mode = gap; mtarget = target; mdone_en = den; inj_at = inj;
        bus.iStart = 1'b1;
    endtask

    task automatic frame_wait();
        for (int i = 0; i < 200 && done_cnt == 0; i++) step();
        chk("frame_done_seen", done_cnt, 1);
    endtask

    initial begin
        int b2b_err;
        int coord_err;
        int exp_bayer[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
        reset = 1'b1;
        bus.iStart = 1'b0; bus.iValid = 1'b0; bus.iData = '0;
        bus.iPipeOutValid = 1'b0; bus.iPipeDone = 1'b0;
        pv_d = '0; mtarget = 0; mdone_en = 1'b0;
        repeat (3) step();
        chk("rst_ready", bus.oReady, 0);
        chk("rst_pvalid", bus.oPipeValid, 0);
        chk("rst_pdata", bus.oPipeData, 0);
        chk("rst_col", bus.oCol, 0);
        chk("rst_row", bus.oRow, 0);
        chk("rst_bayer", bus.oBayer, 0);
        chk("rst_busy", bus.oBusy, 0);
        chk("rst_fdone", bus.oFrameDone, 0);
        chk("rst_error", bus.oError, 0);
        chk("rst_preset", bus.oPipeReset, 1);
        reset = 1'b0;
        step();
        chk("idle_preset", bus.oPipeReset, 0);

        // basic frame, continuous source
        frame_begin(1'b0, 8, 1'b1, -1);
        step();
        chk("basic_busy_prst", bus.oBusy, 1);
        frame_wait();
        chk("basic_prst_cycles", prst_cnt, 2);
        chk("basic_pix_count", dq.size(), 8);
        b2b_err = 0;
        for (int i = 0; i < dq.size(); i++) begin
            chk($sformatf("basic_data%0d", i), dq[i], i + 1);
            chk($sformatf("basic_bayer%0d", i), bq[i], exp_bayer[i]);
            if (vq[i] != vq[0] + i) b2b_err++;
        end
        chk("basic_back_to_back", b2b_err, 0);
        chk("basic_gapfree", gapfree_err, 0);
        chk("basic_zero_flush", zero_flush, 2);
        chk("basic_nonzero_flush", nz_flush, 0);
        chk("basic_err_at_done", err_at_done, 0);
        step();
        chk("basic_done_once", done_cnt, 1);
        chk("basic_idle", bus.oBusy, 0);

        // source gaps
        frame_begin(1'b1, 8, 1'b1, -1);
        frame_wait();
        chk("gap_pix_count", dq.size(), 8);
        chk("gap_mirror", mirror_err, 0);
        chk("gap_hold", hold_err, 0);
        coord_err = 0;
        for (int i = 0; i < dq.size(); i++) begin
            if (dq[i] != i + 1 || cq[i] != i % W || rq[i] != i / W) coord_err++;
        end
        chk("gap_data_coords", coord_err, 0);
        chk("gap_ready_after_last", ready_after, 0);
        chk("gap_nonzero_flush", nz_flush, 0);
        chk("gap_err_at_done", err_at_done, 0);
        step();

        // count mismatch: only 7 output valids
        frame_begin(1'b0, 7, 1'b1, -1);
        frame_wait();
        chk("mismatch_err_at_done", err_at_done, 1);
        step();
        chk("mismatch_idle", bus.oBusy, 0);

        // timeout: done never arrives
        frame_begin(1'b0, 8, 1'b0, -1);
        frame_wait();
        chk("timeout_flush_cycles", done_cyc - last_pix_cyc, FM);
        chk("timeout_err_at_done", err_at_done, 1);
        step();
        chk("timeout_done_once", done_cnt, 1);
        chk("timeout_idle", bus.oBusy, 0);
        chk("timeout_err_sticky", bus.oError, 1);

        // next start clears the error
        frame_begin(1'b0, 8, 1'b1, -1);
        step();
        chk("start_clears_err", bus.oError, 0);
        frame_wait();
        chk("clean_err_at_done", err_at_done, 0);
        step();

        // mid-frame reset after 3 accepted pixels
        frame_begin(1'b0, 8, 1'b1, -1);
        for (int i = 0; i < 50 && sent < 3; i++) step();
        step();
        reset = 1'b1;
        step();
        chk("midrst_preset", bus.oPipeReset, 1);
        chk("midrst_busy", bus.oBusy, 0);
        chk("midrst_pvalid", bus.oPipeValid, 0);
        reset = 1'b0;
        repeat (3) step();
        chk("midrst_no_done", done_cnt, 0);
        frame_begin(1'b0, 8, 1'b1, -1);
        frame_wait();
        chk("midrst_pix_count", dq.size(), 8);
        if (dq.size() > 0) begin
            chk("midrst_first_col", cq[0], 0);
            chk("midrst_first_row", rq[0], 0);
            chk("midrst_first_data", dq[0], 1);
        end
        chk("midrst_err_at_done", err_at_done, 0);
        step();

        // iStart and iPipeDone pulsed during FEED
        frame_begin(1'b0, 8, 1'b1, 3);
        frame_wait();
        inj_at = -1;
        chk("ign_pix_count", dq.size(), 8);
        chk("ign_zero_flush", zero_flush, 2);
        chk("ign_err_at_done", err_at_done, 0);
        step();
        chk("ign_done_once", done_cnt, 1);
        chk("ign_idle", bus.oBusy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
